// File: rtl/sample_word_packer.sv
// Packs SAMPLE_W-bit samples into DRAM_W-bit words, buffers them in a small FIFO and issues addressed DRAM writes.
// Optional feature macro: PACKER_OVF_COUNT_EN builds the saturating dropped-word counter driving ovf_count.
module sample_word_packer #(
    parameter int SAMPLE_W   = 32,
    parameter int DRAM_W     = 128,
    parameter int ADX_W      = 27,
    parameter int ADX_STEP   = 8,
    parameter int PAGE_WORDS = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADX_W-1:0]    base_adx,
    input  logic                we,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                flush,
    input  logic                write_allowed,
    output logic                write_req,
    output logic [DRAM_W-1:0]   dram_data,
    output logic [ADX_W-1:0]    dram_adx,
    output logic                page_full,
    output logic                overflow,
    output logic                busy,
    output logic [31:0]         words_written,
    output logic [15:0]         ovf_count
);

    localparam int LANES  = DRAM_W / SAMPLE_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_L   = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]       PAGE_L    = 32'(PAGE_WORDS);
    localparam logic [ADX_W-1:0]  STEP_L    = ADX_W'(ADX_STEP);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_FULL} state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DRAM_W-1:0]   word_q, word_d;
    logic                pend_q, pend_d;
    logic [DRAM_W-1:0]   pend_word_q, pend_word_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         accepted_q, accepted_d;
    logic [ADX_W-1:0]    next_adx_q, next_adx_d;
    logic                write_req_q, write_req_d;
    logic [DRAM_W-1:0]   dram_data_q, dram_data_d;
    logic [ADX_W-1:0]    dram_adx_q, dram_adx_d;
    logic                page_full_q, page_full_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         words_written_q, words_written_d;

    logic [DRAM_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [DRAM_W-1:0]   word_packed;
    logic [CNT_W-1:0]    occ_after;
    logic                pop, capturing, take, complete, accept, drop;

    // A completed word waits one cycle in the pending stage; room is reserved for it at completion,
    // so the later FIFO push can never fail and drop/page accounting is decided in one place.
    assign pop       = (cnt_q != '0) && write_allowed;
    assign occ_after = cnt_q + CNT_W'(pend_q) - CNT_W'(pop);
    assign capturing = (state_q == S_CAPTURE);
    assign take      = capturing && we;
    assign complete  = capturing && ((take && lane_q == LAST_LANE) || (flush && (take || lane_q != '0)));
    assign accept    = complete && (occ_after < DEPTH_L);
    assign drop      = complete && !accept;

    always_comb begin
        word_packed = word_q;
        for (int l = 0; l < LANES; l++) begin
            if (take && lane_q == LANE_W'(l)) begin
                word_packed[l*SAMPLE_W +: SAMPLE_W] = sample_in;
            end
        end
    end

    // NOTE: every _d gets its default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d         = state_q;
        lane_d          = lane_q;
        word_d          = word_q;
        pend_d          = accept;
        pend_word_d     = word_packed;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        cnt_d           = occ_after;
        accepted_d      = accepted_q;
        next_adx_d      = next_adx_q;
        write_req_d     = pop;
        dram_data_d     = dram_data_q;
        dram_adx_d      = dram_adx_q;
        page_full_d     = page_full_q;
        overflow_d      = overflow_q;
        words_written_d = words_written_q;

        if (complete) begin
            lane_d = '0;
            word_d = '0;
        end else if (take) begin
            lane_d = lane_q + LANE_W'(1);
            word_d = word_packed;
        end

        if (pend_q) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (accept) accepted_d = accepted_q + 32'd1;
        if (drop)   overflow_d = 1'b1;

        if (pop) begin
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            dram_data_d     = fifo_mem[rd_ptr_q];
            dram_adx_d      = next_adx_q;
            next_adx_d      = next_adx_q + STEP_L;
            words_written_d = words_written_q + 32'd1;
            if (words_written_q + 32'd1 == PAGE_L) page_full_d = 1'b1;
        end

        case (state_q)
            S_CAPTURE: begin
                if (accept && accepted_q + 32'd1 == PAGE_L) state_d = S_FULL;
                else if (flush)                             state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cnt_q == '0 && !pend_q) state_d = S_CAPTURE;
            end
            default: ;
        endcase

        // start overrides everything, including a sample presented in the same cycle.
        if (start) begin
            state_d         = S_CAPTURE;
            lane_d          = '0;
            word_d          = '0;
            pend_d          = 1'b0;
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            cnt_d           = '0;
            accepted_d      = '0;
            next_adx_d      = base_adx;
            write_req_d     = 1'b0;
            page_full_d     = 1'b0;
            overflow_d      = 1'b0;
            words_written_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            lane_q          <= '0;
            word_q          <= '0;
            pend_q          <= 1'b0;
            pend_word_q     <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            cnt_q           <= '0;
            accepted_q      <= '0;
            next_adx_q      <= '0;
            write_req_q     <= 1'b0;
            dram_data_q     <= '0;
            dram_adx_q      <= '0;
            page_full_q     <= 1'b0;
            overflow_q      <= 1'b0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            lane_q          <= lane_d;
            word_q          <= word_d;
            pend_q          <= pend_d;
            pend_word_q     <= pend_word_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            cnt_q           <= cnt_d;
            accepted_q      <= accepted_d;
            next_adx_q      <= next_adx_d;
            write_req_q     <= write_req_d;
            dram_data_q     <= dram_data_d;
            dram_adx_q      <= dram_adx_d;
            page_full_q     <= page_full_d;
            overflow_q      <= overflow_d;
            words_written_q <= words_written_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (pend_q) fifo_mem[wr_ptr_q] <= pend_word_q;
    end

`ifdef PACKER_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (start)                              ovf_cnt_d = '0;
        else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_cnt_q <= '0;
        else       ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = '0;
`endif

    assign write_req     = write_req_q;
    assign dram_data     = dram_data_q;
    assign dram_adx      = dram_adx_q;
    assign page_full     = page_full_q;
    assign overflow      = overflow_q;
    assign words_written = words_written_q;
    assign busy          = (lane_q != '0) || pend_q || (cnt_q != '0);

endmodule

// File: doc/sample_word_packer.md
Name: sample_word_packer

Overview:
Parametrised successor to the fixed 32-to-128 DRAM packer in the logic-analyser datapath. Sits between LogicCaptureTop and ddr_memory_interface in the soc_clk domain. Packs SAMPLE_W-bit samples into DRAM_W-bit words and buffers completed words in a small FIFO so the capture side is decoupled from write_allowed backpressure. Issues addressed write requests and supports partial-word flush, page limit and sticky overflow reporting.

Parameters:
SAMPLE_W, 32, bits per sample; DRAM_W must be an integer multiple of SAMPLE_W
DRAM_W, 128, bits per DRAM write word
ADX_W, 27, DRAM address width
ADX_STEP, 8, address increment per DRAM word
PAGE_WORDS, 1024, DRAM words per capture page (≥1)
FIFO_DEPTH, 4, buffered DRAM words; power of 2, ≥2
Derived, not a parameter: LANES = DRAM_W/SAMPLE_W.

Ports:
clk  in  1  soc clock
reset  in  1  asynchronous, active-high
start  in  1  1-cycle pulse; latch base_adx, clear all counters and flags, enter CAPTURE
base_adx  in  ADX_W  page start address, sampled on start
we  in  1  sample valid
sample_in  in  SAMPLE_W  sample data
flush  in  1  1-cycle pulse; emit the partial word
write_allowed  in  1  memory interface can accept a request this cycle
write_req  out  1  1-cycle write request
dram_data  out  DRAM_W  write data, valid while write_req=1
dram_adx  out  ADX_W  write address, valid while write_req=1
page_full  out  1  sticky; PAGE_WORDS words issued
overflow  out  1  sticky; a completed word was dropped
busy  out  1  partial word held or FIFO non-empty
words_written  out  32  DRAM words issued since start
ovf_count  out  16  dropped-word count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FIFO empty, lane=0, state IDLE. Reset asserted mid-operation discards all data immediately.
- States:
  - IDLE: ignore we and flush; start → CAPTURE.
  - CAPTURE: pack samples; flush → DRAIN; page limit reached → FULL.
  - DRAIN: accept no samples; FIFO empty → CAPTURE.
  - FULL: ignore we and flush; FIFO drains.
  - start from any state → CAPTURE after clearing state.
- Packing:
  - Sample n of a word occupies bits [n*SAMPLE_W +: SAMPLE_W]; the first sample goes in the LSBs.
  - The lane counter wraps at LANES.
  - When the last lane is written, the word is pushed to the FIFO on the next clock.
- Flush:
  - lane≠0: zero-fill the remaining lanes, push the word, lane→0.
  - lane=0: no push; DRAIN only until the FIFO is empty.
  - we and flush in the same cycle: the sample is packed first, then the flush applies. If that sample completes the word, flush pushes nothing extra.
- Drain side:
  - write_req=1 for exactly one cycle when the FIFO is non-empty and write_allowed=1 (registered outputs).
  - Latency: the word-completing sample at edge t gives write_req at cycle t+2 at the earliest.
  - A FIFO push and pop in the same cycle are both honoured.
- Addressing:
  - dram_adx = base + words_written*ADX_STEP, modulo 2^ADX_W (wraps silently).
  - words_written increments on each write_req.
- Page limit:
  - A word pushed to the FIFO counts toward the limit.
  - When PAGE_WORDS words have been pushed, further we is ignored and the state is FULL.
  - page_full asserts on the write_req cycle of word PAGE_WORDS and holds until start or reset.
- Overflow:
  - A word completing while the FIFO is full is dropped. overflow←1 (sticky) and lane→0.
  - A dropped word does not count toward the page limit.
- start together with we: start wins and the sample is discarded.

Optional Feature:
PACKER_OVF_COUNT_EN
- Defined: ovf_count increments on each dropped word, saturates at 16'hFFFF, and clears on start or reset.
- Undefined: ovf_count is tied to 0 and no counter logic is built. The overflow flag is unaffected either way.

Test Plan:
Unless a line says otherwise, the bench uses defaults with base_adx=0x100 and write_allowed=1.
1. start, then samples 0x11111111, 0x22222222, 0x33333333, 0x44444444 → one write_req 2 cycles after the 4th sample; dram_data=0x44444444_33333333_22222222_11111111, dram_adx=0x100, words_written=1.
2. Continue with 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, then flush → dram_data=0x00000000_CCCCCCCC_BBBBBBBB_AAAAAAAA, dram_adx=0x108; busy=0 afterwards. A second flush with lane=0 → no write_req.
3. write_allowed=0 and 24 samples (6 words, FIFO_DEPTH=4) → overflow=1 at the 5th word; with the macro defined, ovf_count=2. Then write_allowed=1 → exactly 4 write_reqs, addresses 0x100–0x118, holding the first four words.
4. PAGE_WORDS=4 and 20 samples → 4 write_reqs; page_full=1 on the 4th; samples 17–20 ignored. A start pulse then clears page_full, words_written and overflow.
5. base_adx=0x7FFFFF8 and 8 samples → dram_adx values 0x7FFFFF8 then 0x0000000.
6. Assert reset asynchronously after 2 samples with 1 word queued → all outputs 0 immediately, no write_req. After release, start plus 4 samples → a clean word at base_adx.
